// File: rtl/uw_window_buf.sv
// uw_window_buf -- search-window buffer for block motion estimation.
//
// Holds a W x W pixel window (W = BLK + 2*RANGE), loaded one column at a time
// over a BUS_W-bit write bus, and serves a registered BLK x BLK candidate block
// at a signed (row, column) offset in [-RANGE, +RANGE]. A slide operation
// shifts the window one column left and appends a single new column on the
// right, so consecutive macroblocks reuse the overlapping columns.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state including storage
//   start      one-cycle request to begin a load (honoured only while ready)
//   mode       sampled with start: 0 = full load of W columns, 1 = slide by one
//   WE         write beat valid (LOAD/SLIDE only)
//   DataIN     write beat, pixels MSB-first, top row first
//   rd_req     read request, accepted in any state
//   R_ROW      signed row offset
//   R_COL      signed column offset
//   ready      high while idle
//   win_valid  window contents complete and usable
//   rd_valid   DataOUT / rd_err valid (one cycle after rd_req)
//   rd_err     requested offset out of range; DataOUT kept
//   DataOUT    candidate block, column 0 at the MSB end, row 0 first in each column
module uw_window_buf #(
  parameter int BLK   = 16,
  parameter int RANGE = 3,
  parameter int PIX_W = 8,
  parameter int BUS_W = 64,
  parameter int OFF_W = $clog2(2 * RANGE + 1) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       WE,
  input  logic [BUS_W-1:0]           DataIN,
  input  logic                       rd_req,
  input  logic [OFF_W-1:0]           R_ROW,
  input  logic [OFF_W-1:0]           R_COL,
  output logic                       ready,
  output logic                       win_valid,
  output logic                       rd_valid,
  output logic                       rd_err,
  output logic [BLK*BLK*PIX_W-1:0]   DataOUT
);

  localparam int W      = BLK + 2 * RANGE;
  localparam int COL_W  = W * PIX_W;
  localparam int BEATS  = (COL_W + BUS_W - 1) / BUS_W;
  localparam int PPB    = BUS_W / PIX_W;            // pixels per beat
  localparam int IDX_W  = $clog2(W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OUT_W  = BLK * BLK * PIX_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SLIDE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     col_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 active;
  logic                 commit;

  // Window storage indexed [column][row]; plus the staging column.
  logic [PIX_W-1:0]     win   [W][W];
  logic [PIX_W-1:0]     stage [W];
  logic [PIX_W-1:0]     col_new [W];

  // Read-path scratch.
  int                   row_off, col_off, base_r, base_c;
  logic                 rd_bad;
  logic [OUT_W-1:0]     blk_nxt;

  assign active = (state != IDLE);
  assign commit = active && WE && (beat_cnt == LAST_BEAT);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !mode)                 state_nxt = LOAD;
        else if (start && mode && win_valid) state_nxt = SLIDE;
      end
      LOAD:    if (commit && col_cnt == LAST_COL) state_nxt = IDLE;
      SLIDE:   if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // ------------------------------------------------------- counters/flags
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt   <= '0;
      beat_cnt  <= '0;
      win_valid <= 1'b0;
    end else if (state == IDLE) begin
      // A beat arriving together with start is dropped.
      if (start && !mode) begin
        col_cnt   <= '0;
        beat_cnt  <= '0;
        win_valid <= 1'b0;
      end else if (start && mode && win_valid) begin
        beat_cnt <= '0;
      end
    end else if (WE) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
        if (state == LOAD) begin
          if (col_cnt == LAST_COL) begin
            col_cnt   <= '0;
            win_valid <= 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Staging column with the current beat merged in; this is what a commit
  // writes, so the final beat lands in the window on the same edge.
  always_comb begin
    int idx;
    col_new = stage;
    for (int k = 0; k < PPB; k++) begin
      idx = int'(beat_cnt) * PPB + k;
      if (idx < W) col_new[IDX_W'(idx)] = DataIN[BUS_W-1-k*PIX_W -: PIX_W];
    end
  end

  // NOTE: the window is a flop array, not a RAM, because reset must clear it
  // and a slide moves every column at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < W; r++) stage[r] <= '0;
      for (int c = 0; c < W; c++)
        for (int r = 0; r < W; r++) win[c][r] <= '0;
    end else if (active && WE) begin
      stage <= col_new;
      if (commit) begin
        if (state == LOAD) begin
          win[col_cnt] <= col_new;
        end else begin
          for (int c = 0; c < W - 1; c++) win[c] <= win[c + 1];
          win[W-1] <= col_new;
        end
      end
    end
  end

  // ---------------------------------------------------------- read path
  always_comb begin
    row_off = int'($signed(R_ROW));
    col_off = int'($signed(R_COL));
    rd_bad  = (row_off < -RANGE) || (row_off > RANGE) ||
              (col_off < -RANGE) || (col_off > RANGE);
    // Out-of-range offsets fall back to the centre so the gather never
    // indexes outside the window; the result is discarded anyway.
    base_r  = rd_bad ? RANGE : RANGE + row_off;
    base_c  = rd_bad ? RANGE : RANGE + col_off;
    blk_nxt = '0;
    for (int c = 0; c < BLK; c++)
      for (int r = 0; r < BLK; r++)
        blk_nxt[OUT_W-1-(c*BLK+r)*PIX_W -: PIX_W] =
          win[IDX_W'(base_c + c)][IDX_W'(base_r + r)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      DataOUT  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && rd_bad;
      if (rd_req && !rd_bad) DataOUT <= blk_nxt;
    end
  end

endmodule

// File: tb/tb_uw_window_buf.sv
// Directed bench for uw_window_buf with a read scoreboard: each read pushes
// the block expected from a reference window model, and the entry is popped
// and compared when rd_valid comes back.
module tb_uw_window_buf;

  localparam int BLK   = 16;
  localparam int RANGE = 3;
  localparam int PIX_W = 8;
  localparam int BUS_W = 64;
  localparam int OFF_W = 4;
  localparam int W     = BLK + 2 * RANGE;
  localparam int PPB   = BUS_W / PIX_W;
  localparam int BEATS = 3;
  localparam int OUT_W = BLK * BLK * PIX_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               mode;
  logic               WE;
  logic [BUS_W-1:0]   DataIN;
  logic               rd_req;
  logic [OFF_W-1:0]   R_ROW;
  logic [OFF_W-1:0]   R_COL;
  logic               ready;
  logic               win_valid;
  logic               rd_valid;
  logic               rd_err;
  logic [OUT_W-1:0]   DataOUT;

  uw_window_buf #(
    .BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W), .BUS_W(BUS_W), .OFF_W(OFF_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .WE(WE),
    .DataIN(DataIN), .rd_req(rd_req), .R_ROW(R_ROW), .R_COL(R_COL),
    .ready(ready), .win_valid(win_valid), .rd_valid(rd_valid),
    .rd_err(rd_err), .DataOUT(DataOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             err;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       m_win [W][W];   // reference window [column][row]
  logic [7:0]       pre   [W][W];
  logic [7:0]       cur_col [W];
  logic [OUT_W-1:0] m_last;
  int               vectors = 0;
  int               miscompares = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------- checks
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [OUT_W-1:0] obs,
                           input logic [OUT_W-1:0] exp);
    int bad;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      bad = -1;
      for (int i = 0; i < OUT_W / 8; i++)
        if (bad < 0 && obs[OUT_W-1-i*8 -: 8] !== exp[OUT_W-1-i*8 -: 8]) bad = i;
      if (bad < 0) bad = 0;
      $error("FAIL %s: byte %0d (col %0d row %0d) observed %h expected %h",
             tag, bad, bad / BLK, bad % BLK,
             obs[OUT_W-1-bad*8 -: 8], exp[OUT_W-1-bad*8 -: 8]);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] pat(input int c, input int r);
    return 8'((c * W + r) % 256);
  endfunction

  function automatic logic [OUT_W-1:0] model_block(input int ro, input int co);
    logic [OUT_W-1:0] b;
    b = '0;
    for (int c = 0; c < BLK; c++)
      for (int r = 0; r < BLK; r++)
        b[OUT_W-1-(c*BLK+r)*8 -: 8] = m_win[RANGE+co+c][RANGE+ro+r];
    return b;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < W; c++)
      for (int r = 0; r < W; r++) m_win[c][r] = 8'h00;
    m_last = '0;
    sb.delete();
  endtask

  // ------------------------------------------------------------- drivers
  // Advance one clock, return inputs to idle, then retire any read result.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    mode   = 1'b0;
    WE     = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b0;
    if (rd_valid !== 1'b0 || sb.size() > 0) begin
      check_bit("rd_valid", rd_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_bit("rd_err", rd_err, e.err);
        check_blk("DataOUT", DataOUT, e.data);
      end
    end
  endtask

  task automatic issue_read(input int ro, input int co);
    exp_t e;
    rd_req = 1'b1;
    R_ROW  = OFF_W'(ro);
    R_COL  = OFF_W'(co);
    if (ro < -RANGE || ro > RANGE || co < -RANGE || co > RANGE) begin
      e.err  = 1'b1;
      e.data = m_last;
    end else begin
      e.err  = 1'b0;
      e.data = model_block(ro, co);
      m_last = e.data;
    end
    sb.push_back(e);
  endtask

  // Unused trailing pixel slots carry random junk that must be ignored.
  task automatic drive_beat(input int b);
    int idx;
    WE = 1'b1;
    for (int k = 0; k < PPB; k++) begin
      idx = b * PPB + k;
      if (idx < W) DataIN[BUS_W-1-k*8 -: 8] = cur_col[idx];
      else         DataIN[BUS_W-1-k*8 -: 8] = 8'($urandom);
    end
  endtask

  task automatic fill_pattern(input int c);
    for (int r = 0; r < W; r++) cur_col[r] = pat(c, r);
  endtask

  // Full load of the pattern window with `gaps` single-cycle WE holes.
  task automatic full_load(input int gaps);
    bit hole [W*BEATS];
    int n, rise_at, placed, pos;
    for (int i = 0; i < W * BEATS; i++) hole[i] = 1'b0;
    placed = 0;
    while (placed < gaps) begin
      pos = int'($urandom_range(W * BEATS - 1, 1));
      if (!hole[pos]) begin
        hole[pos] = 1'b1;
        placed++;
      end
    end
    // start with a simultaneous junk beat, which must be dropped
    start  = 1'b1;
    mode   = 1'b0;
    WE     = 1'b1;
    DataIN = {BUS_W{1'b1}};
    cycle();
    check_bit("ready_after_start", ready, 1'b0);
    check_bit("win_valid_cleared", win_valid, 1'b0);
    n = 0;
    rise_at = -1;
    for (int c = 0; c < W; c++) begin
      fill_pattern(c);
      for (int b = 0; b < BEATS; b++) begin
        if (hole[c * BEATS + b]) begin
          WE     = 1'b0;
          DataIN = {$urandom, $urandom};
          cycle();
          n++;
          if (win_valid === 1'b1 && rise_at < 0) rise_at = n;
        end
        drive_beat(b);
        cycle();
        n++;
        if (win_valid === 1'b1 && rise_at < 0) rise_at = n;
      end
      for (int r = 0; r < W; r++) m_win[c][r] = cur_col[r];
    end
    check_int("win_valid_rise_cycle", rise_at, W * BEATS + gaps);
    check_bit("ready_after_load", ready, 1'b1);
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    WE     = 1'b0;
    DataIN = '0;
    rd_req = 1'b0;
    R_ROW  = '0;
    R_COL  = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check_bit("rst_ready", ready, 1'b1);
    check_bit("rst_win_valid", win_valid, 1'b0);
    check_bit("rst_rd_valid", rd_valid, 1'b0);
    check_bit("rst_rd_err", rd_err, 1'b0);
    check_blk("rst_DataOUT", DataOUT, '0);

    // full load, then reads at the centre and the corners
    full_load(0);
    issue_read(0, 0);
    cycle();
    check_blk("tl_0_0", {{(OUT_W-8){1'b0}}, DataOUT[OUT_W-1 -: 8]},
              {{(OUT_W-8){1'b0}}, pat(RANGE, RANGE)});
    issue_read(-3, -3);
    cycle();
    check_blk("tl_m3_m3", {{(OUT_W-8){1'b0}}, DataOUT[OUT_W-1 -: 8]},
              {{(OUT_W-8){1'b0}}, 8'h00});
    issue_read(3, 3);
    cycle();
    issue_read(2, -1);   // back-to-back with the next read
    cycle();
    issue_read(-1, 2);
    cycle();

    // out-of-range offsets: error flagged, DataOUT held
    issue_read(4, 0);
    cycle();
    issue_read(0, -4);
    cycle();

    // slide in an all-0xFF column; a read on the final beat sees the old window
    for (int c = 0; c < W; c++)
      for (int r = 0; r < W; r++) pre[c][r] = m_win[c][r];
    start = 1'b1;
    mode  = 1'b1;
    cycle();
    check_bit("ready_in_slide", ready, 1'b0);
    for (int r = 0; r < W; r++) cur_col[r] = 8'hFF;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b);
      if (b == BEATS - 1) begin
        issue_read(0, 0);
        for (int c = 0; c < W - 1; c++)
          for (int r = 0; r < W; r++) m_win[c][r] = m_win[c + 1][r];
        for (int r = 0; r < W; r++) m_win[W-1][r] = 8'hFF;
      end
      cycle();
    end
    check_bit("ready_after_slide", ready, 1'b1);
    check_bit("win_valid_after_slide", win_valid, 1'b1);
    issue_read(0, 3);
    cycle();
    begin
      logic [BLK*8-1:0] c0_exp;
      for (int r = 0; r < BLK; r++) c0_exp[BLK*8-1-r*8 -: 8] = pre[7][RANGE + r];
      check_blk("slide_col15_ff", {{(OUT_W-BLK*8){1'b0}}, DataOUT[BLK*8-1 -: BLK*8]},
                {{(OUT_W-BLK*8){1'b0}}, {BLK{8'hFF}}});
      check_blk("slide_col0_old7", {{(OUT_W-BLK*8){1'b0}}, DataOUT[OUT_W-1 -: BLK*8]},
                {{(OUT_W-BLK*8){1'b0}}, c0_exp});
    end

    // load with five WE gaps: same contents, win_valid five cycles later
    full_load(5);
    issue_read(0, 0);
    cycle();
    issue_read(-3, -3);
    cycle();
    issue_read(3, 3);
    cycle();
    issue_read(-2, 1);
    cycle();

    // reset in the middle of a load (after 30 beats), with a read along the way
    start = 1'b1;
    mode  = 1'b0;
    cycle();
    for (int i = 0; i < 30; i++) begin
      fill_pattern(i / BEATS);
      drive_beat(i % BEATS);
      if (i == 20) issue_read(1, 1);
      cycle();
      if (i % BEATS == BEATS - 1)
        for (int r = 0; r < W; r++) m_win[i / BEATS][r] = cur_col[r];
    end
    reset = 1'b1;
    fill_pattern(10);
    drive_beat(0);
    cycle();
    model_clear();
    check_bit("mid_rst_ready", ready, 1'b1);
    check_bit("mid_rst_win_valid", win_valid, 1'b0);
    check_bit("mid_rst_rd_valid", rd_valid, 1'b0);
    check_bit("mid_rst_rd_err", rd_err, 1'b0);
    check_blk("mid_rst_DataOUT", DataOUT, '0);

    // slide request with no valid window is ignored
    start = 1'b1;
    mode  = 1'b1;
    cycle();
    check_bit("slide_ignored_ready", ready, 1'b1);
    for (int r = 0; r < W; r++) cur_col[r] = 8'hFF;
    drive_beat(0);
    cycle();
    issue_read(0, 0);    // storage was cleared and must still be zero
    cycle();
    check_bit("slide_ignored_win_valid", win_valid, 1'b0);

    // fresh load after the abort
    full_load(0);
    issue_read(1, -2);
    cycle();
    issue_read(0, 0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
